// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) round helpers
// for the iterative encrypt core.
package aes_pkg;

   localparam int         AES_NR    = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] GF_POLY   = 8'h1B;

   typedef enum logic {IDLE, RUN} state_t;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   // One state column, row 0 in the top byte.
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte k sits at [127-8k -: 8]; row r of column c is byte r+4c.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational table lookup.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Entry 0 occupies the top byte, so entry a lives at bit offset 8*(255-a).
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};

   assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, key schedule on the fly.
// Optional AES_ENC_ROUND_DBG_EN exposes dbg_round/dbg_state for round tracing.
module aes_enc_iter
   import aes_pkg::*;
#(
   parameter bit OUT_HOLD = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] IN,
   input  logic [127:0] KEY,
   input  logic         enable,
   output logic         ready,
   output logic [127:0] OUT,
   output logic         valid_out
`ifdef AES_ENC_ROUND_DBG_EN
   ,
   output logic [3:0]   dbg_round,
   output logic [127:0] dbg_state
`endif
);

   state_t       state, state_n;
   logic [127:0] st, rk, out_reg;
   logic [7:0]   rcon;
   logic [3:0]   rnd;

   logic [127:0] sb, sr, mc, st_n, rk_n;
   logic [31:0]  rot, sw, temp;
   logic         final_rnd, accept;

   assign final_rnd = (state == RUN) && (rnd == 4'(AES_NR));
   assign ready     = (state == IDLE) || final_rnd;
   assign accept    = enable && ready;

   // State S-box bank; SubBytes is byte-local so slot order is irrelevant.
   for (genvar i = 0; i < 16; i++) begin : g_sb
      aes_sbox u_sb (.a(st[8*i +: 8]), .y(sb[8*i +: 8]));
   end

   // Key-schedule S-boxes see RotWord of the last key word.
   assign rot = {rk[23:0], rk[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_kb
      aes_sbox u_kb (.a(rot[8*i +: 8]), .y(sw[8*i +: 8]));
   end

   assign temp           = sw ^ {rcon, 24'h000000};
   assign rk_n[127:96]   = rk[127:96] ^ temp;
   assign rk_n[95:64]    = rk[95:64]  ^ rk_n[127:96];
   assign rk_n[63:32]    = rk[63:32]  ^ rk_n[95:64];
   assign rk_n[31:0]     = rk[31:0]   ^ rk_n[63:32];

   always_comb begin
      sr = shift_rows(sb);
      mc = '0;
      for (int c = 0; c < 4; c++)
         mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
      st_n = ((rnd == 4'(AES_NR)) ? sr : mc) ^ rk_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept) state_n = RUN;
         RUN:  if (final_rnd && !accept) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A new block may load on the same edge the old one retires; the
   // retiring result goes to out_reg from st_n before st is overwritten.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= '0;
         rk        <= '0;
         rcon      <= '0;
         rnd       <= '0;
         out_reg   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= final_rnd;
         if (final_rnd) out_reg <= st_n;
         if (accept) begin
            st   <= IN ^ KEY;
            rk   <= KEY;
            rcon <= RCON_INIT;
            rnd  <= 4'd1;
         end else if (state == RUN) begin
            st   <= st_n;
            rk   <= rk_n;
            rcon <= xtime(rcon);
            rnd  <= rnd + 4'd1;
         end
      end
   end

   if (OUT_HOLD) begin : g_hold
      assign OUT = out_reg;
   end else begin : g_gate
      assign OUT = valid_out ? out_reg : '0;
   end

`ifdef AES_ENC_ROUND_DBG_EN
   assign dbg_round = (state == RUN) ? rnd : 4'd0;
   assign dbg_state = st;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: FIPS vector table, back-to-back, mid-block reset,
// and random blocks against an arithmetic AES-128 model.
module tb_aes_enc_iter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enable = 1'b0;
   logic [127:0] IN = '0, KEY = '0;
   logic         ready, valid_out;
   logic [127:0] OUT;
`ifdef AES_ENC_ROUND_DBG_EN
   logic [3:0]   dbg_round;
   logic [127:0] dbg_state;
`endif
   logic [127:0] dbg1 = '0;

   aes_enc_iter dut (
      .clk(clk), .rst(rst), .IN(IN), .KEY(KEY), .enable(enable),
      .ready(ready), .OUT(OUT), .valid_out(valid_out)
`ifdef AES_ENC_ROUND_DBG_EN
      , .dbg_round(dbg_round), .dbg_state(dbg_state)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] sbt [256];

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;
   vec_t vt [3];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t = {b, b};
      return t[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
         if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tw;
      logic [7:0]   rc = 8'h01;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tw = w[i-1];
         if (i % 4 == 0) begin
            tw = {tw[23:0], tw[31:24]};
            tw = {sbt[tw[31:24]], sbt[tw[23:16]], sbt[tw[15:8]], sbt[tw[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tw;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[row+4*c] = sbt[s[row+4*((c+row)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
               s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
            end else begin
               for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
            end
            for (int k = 0; k < 4; k++) s[4*c+k] ^= w[4*r+c][31-8*k -: 8];
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Starts one block from posedge+1; returns when valid_out is seen (or timeout).
   task automatic run_one(input logic [127:0] key, input logic [127:0] pt, input bit spam,
                          output logic [127:0] ct, output int lat, output bit rdy_ok);
      KEY = key; IN = pt; enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0; rdy_ok = 1'b1; lat = 0;
      while (!valid_out && lat < 20) begin
         if (ready !== (lat == 9)) rdy_ok = 1'b0;
         if (spam && lat < 8) begin
            enable = 1'($urandom_range(0, 1));
            IN  = {$urandom(), $urandom(), $urandom(), $urandom()};
            KEY = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else enable = 1'b0;
         @(posedge clk); #1;
         lat++;
`ifdef AES_ENC_ROUND_DBG_EN
         if (lat == 1) dbg1 = dbg_state;
`endif
      end
      enable = 1'b0;
      ct = OUT;
   endtask

   task automatic block_check(input string tag, input logic [127:0] key,
                              input logic [127:0] pt, input logic [127:0] exp, input bit spam);
      logic [127:0] ct;
      int lat;
      bit rdy_ok;
      run_one(key, pt, spam, ct, lat, rdy_ok);
      chk({tag, "_latency"}, 128'(lat), 128'd10);
      chk({tag, "_ct"}, ct, exp);
      chk({tag, "_ready"}, 128'(rdy_ok), 128'd1);
      @(posedge clk); #1;
      chk({tag, "_pulse_width"}, 128'(valid_out), 128'd0);
      chk({tag, "_out_hold"}, OUT, exp);
   endtask

   initial begin
      logic [127:0] k, p, o1, o2;
      int t1, t2, n, nv;

      for (int a = 0; a < 256; a++) sbt[a] = sbox_calc(8'(a));

      vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
      vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      #12;
      chk("reset_ready", 128'(ready), 128'd1);
      chk("reset_valid", 128'(valid_out), 128'd0);
      chk("reset_out", OUT, 128'd0);
      @(posedge clk); #1 rst = 1'b1;

      for (int i = 0; i < 3; i++) begin
         block_check($sformatf("vec%0d", i), vt[i].key, vt[i].pt, vt[i].ct, i == 1);
`ifdef AES_ENC_ROUND_DBG_EN
         if (i == 1) chk("dbg_round1_state", dbg1, 128'ha49c7ff2689f352b6b5bea43026a5049);
`endif
      end

      // Back-to-back with enable held high.
      KEY = vt[0].key; IN = vt[0].pt; enable = 1'b1;
      @(posedge clk); #1;
      KEY = vt[1].key; IN = vt[1].pt;
      n = 0; t1 = 0; t2 = 0; o1 = '0; o2 = '0;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); #1;
         if (c == 10) enable = 1'b0;
         if (valid_out) begin
            if (n == 0) begin t1 = c; o1 = OUT; end
            else if (n == 1) begin t2 = c; o2 = OUT; end
            n++;
         end
      end
      chk("b2b_first_time", 128'(t1), 128'd10);
      chk("b2b_first_ct", o1, vt[0].ct);
      chk("b2b_second_time", 128'(t2), 128'd20);
      chk("b2b_second_ct", o2, vt[1].ct);
      chk("b2b_pulse_count", 128'(n), 128'd2);

      // Reset at round 5 aborts the block.
      KEY = vt[0].key; IN = vt[0].pt; enable = 1'b1;
      @(posedge clk); #1 enable = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_ready", 128'(ready), 128'd1);
      chk("midrst_valid", 128'(valid_out), 128'd0);
      chk("midrst_out", OUT, 128'd0);
      @(posedge clk); #1 rst = 1'b1;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (valid_out) nv++;
      end
      chk("midrst_no_valid", 128'(nv), 128'd0);
      block_check("after_rst", vt[0].key, vt[0].pt, vt[0].ct, 1'b0);

      // Random blocks against the model.
      for (int r = 0; r < 20; r++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         block_check($sformatf("rand%0d", r), k, p, ref_enc(k, p), r[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
